// File: rtl/p1_pool_write_pkg.sv
// Shared definitions for the P1 pooling stage and the P1 memory reader.
// Holds the frame geometry, the default pixel width and the P1 address type.
package p1_pool_write_pkg;
  localparam int P1_DATA_W = 16;   // default signed pixel width
  localparam int IN_DIM    = 24;   // conv1 output frame is IN_DIM x IN_DIM
  localparam int OUT_DIM   = 12;   // pooled frame is OUT_DIM x OUT_DIM
  localparam int P1_DEPTH  = 144;  // OUT_DIM*OUT_DIM pooled words

  // Address into P1 memory, shared with the reader side.
  typedef logic [7:0] p1_addr_t;
endpackage

// File: rtl/p1_pool_write_if.sv
// Pixel-in / pooled-write-out bus of the P1 pooling stage.
//   in_valid, in_data : conv1 pixel stream (master -> slave)
//   in_ready          : stage can take a pixel (slave -> master)
//   wr_en/addr/data   : write strobe into P1 memory (slave -> master)
//   done              : full pooled frame written, sticky until reset
interface p1_pool_write_if import p1_pool_write_pkg::*; #(
  parameter int DATA_W = P1_DATA_W
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     wr_en;
  p1_addr_t                 wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     done;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/p1_pool_write_max2.sv
// p1_max2: combinational two's-complement max of two DATA_W operands.
//   a_i, b_i : signed operands
//   max_o    : larger of the two (ties return a_i, same value either way)
module p1_max2 #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] max_o
);
  assign max_o = (b_i > a_i) ? b_i : a_i;
endmodule

// File: rtl/p1_pool_write.sv
// p1_pool_write: 2x2 max-pool of a 24x24 row-major conv1 frame into a
// 12x12 P1 memory image, one write per completed window.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : stage enable; low freezes all pooling state
//   bus        : slave side of p1_pool_write_if (pixel in, P1 write out)
// Even rows fold each horizontal pair into a 12-entry line buffer; odd rows
// fold their pair with the buffered one and emit the window max.
module p1_pool_write import p1_pool_write_pkg::*; #(
  parameter int DATA_W = P1_DATA_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  p1_pool_write_if.slave bus
);
  typedef logic signed [DATA_W-1:0] pix_t;

  localparam logic [4:0] DIM_LAST  = 5'(IN_DIM - 1);
  localparam p1_addr_t   ADDR_LAST = p1_addr_t'(P1_DEPTH - 1);

  logic [4:0] col_q, row_q;
  pix_t       h_q;
  pix_t       lb_q [OUT_DIM];
  logic       wr_en_q, done_q;
  p1_addr_t   wr_addr_q;
  pix_t       wr_data_q;

  logic       accept, pair_done, emit, lb_wr;
  logic [3:0] lb_idx;
  pix_t       pair_max, quad_max;

  assign bus.in_ready = enable && !done_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign lb_idx       = col_q[4:1];
  assign pair_done    = accept && col_q[0];
  assign emit         = pair_done && row_q[0];   // odd row closes a window
  assign lb_wr        = pair_done && !row_q[0];  // even row parks its pair

  p1_max2 #(.DATA_W(DATA_W)) u_pair_max (
    .a_i  (h_q),
    .b_i  (bus.in_data),
    .max_o(pair_max)
  );

  p1_max2 #(.DATA_W(DATA_W)) u_quad_max (
    .a_i  (lb_q[lb_idx]),
    .b_i  (pair_max),
    .max_o(quad_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      h_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (col_q == DIM_LAST) begin
          col_q <= '0;
          row_q <= (row_q == DIM_LAST) ? 5'd0 : row_q + 5'd1;
        end else begin
          col_q <= col_q + 5'd1;
        end
        if (!col_q[0]) h_q <= bus.in_data;
      end

      // Strobe is computed from the accept alone, so a strobe already
      // registered completes even if enable drops on the next cycle.
      wr_en_q <= emit;
      if (emit) wr_data_q <= quad_max;

      // Address advances after each write; the last write raises done
      // instead, leaving the address parked at the final index.
      if (wr_en_q) begin
        if (wr_addr_q == ADDR_LAST) done_q    <= 1'b1;
        else                        wr_addr_q <= wr_addr_q + 8'd1;
      end
    end
  end

  // Line buffer needs no reset: every entry is written on an even row
  // before an odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_wr) lb_q[lb_idx] <= pair_max;
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_p1_pool_write.sv
module tb_p1_pool_write;
  import p1_pool_write_pkg::*;

  logic clk = 1'b0;
  logic reset, enable;
  always #5 clk = ~clk;

  p1_pool_write_if #(.DATA_W(16)) bus ();

  p1_pool_write #(.DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard of expected P1 writes
  typedef struct {
    p1_addr_t           addr;
    logic signed [15:0] data;
  } wr_t;
  wr_t sbq[$];
  wr_t e;

  logic signed [15:0] mem [P1_DEPTH];
  int                 wr_cnt;
  bit                 sb_en = 1'b0;
  logic signed [15:0] last_wd;

  // Frame patterns
  function automatic logic signed [15:0] pix(int pat, int r, int c);
    case (pat)
      0:       return 16'(r * 24 + c);
      1: begin
        if (r == 1 && c == 0)   return -16'sd3;
        if (r == 22 && c == 23) return -16'sd7;
        return -16'sd100;
      end
      default: return 16'(-(r * 24 + c));
    endcase
  endfunction

  function automatic logic signed [15:0] win_max(int pat, int k);
    logic signed [15:0] m, v;
    int r0, c0;
    r0 = 2 * (k / 12);
    c0 = 2 * (k % 12);
    m  = pix(pat, r0, c0);
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = pix(pat, r0 + dr, c0 + dc);
        if (v > m) m = v;
      end
    return m;
  endfunction

  // Monitor: pop/compare on every write, check wr_data holds otherwise
  always @(negedge clk) begin
    if (reset) begin
      last_wd = '0;
    end else if (sb_en) begin
      if (bus.wr_en) begin
        wr_cnt++;
        if (bus.wr_addr < 8'(P1_DEPTH)) mem[bus.wr_addr] = bus.wr_data;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wr addr=%0d data=%0d expected=no_write",
                   bus.wr_addr, bus.wr_data);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", bus.wr_data, e.data);
        end
        last_wd = bus.wr_data;
      end else begin
        chk("wr_data_hold", bus.wr_data, last_wd);
      end
    end
  end

  task automatic reset_seq();
    sb_en        = 1'b0;
    reset        = 1'b1;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",    32'(bus.wr_en), 0);
    chk("rst_wr_addr",  32'(bus.wr_addr), 0);
    chk("rst_wr_data",  bus.wr_data, 0);
    chk("rst_done",     32'(bus.done), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    sbq.delete();
    for (int i = 0; i < P1_DEPTH; i++) mem[i] = 16'sh7fff;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready_en0", 32'(bus.in_ready), 0);
    enable = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_en1", 32'(bus.in_ready), 1);
    wr_cnt  = 0;
    last_wd = '0;
    sb_en   = 1'b1;
  endtask

  task automatic drive_pixel(int pat, int r, int c, bit gaps);
    wr_t w;
    if (gaps && $urandom_range(0, 2) == 0)
      repeat ($urandom_range(1, 4)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        @(posedge clk); #1;
      end
    if (sb_en && (r % 2 == 1) && (c % 2 == 1)) begin
      w.addr = 8'((r / 2) * 12 + c / 2);
      w.data = win_max(pat, (r / 2) * 12 + c / 2);
      sbq.push_back(w);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = pix(pat, r, c);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Enable low with garbage on the bus: nothing may be accepted
  task automatic enable_gap();
    enable = 1'b0;
    repeat (3) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      #1;
      chk("en_low_in_ready", 32'(bus.in_ready), 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    enable = 1'b1;
  endtask

  typedef struct {
    string              name;
    int                 pat;
    bit                 gaps;
    bit                 enwin;
    bit                 pre_abort;
    logic signed [15:0] exp0;
    logic signed [15:0] exp143;
  } scen_t;
  scen_t tbl [4];

  initial begin
    tbl[0] = '{"ramp_after_abort", 0, 1'b0, 1'b0, 1'b1,  16'sd25,   16'sd575};
    tbl[1] = '{"neg100_spots",     1, 1'b0, 1'b0, 1'b0, -16'sd3,   -16'sd7};
    tbl[2] = '{"ramp_gaps_enable", 0, 1'b1, 1'b1, 1'b0,  16'sd25,   16'sd575};
    tbl[3] = '{"neg_ramp_gaps",    2, 1'b1, 1'b0, 1'b0,  16'sd0,   -16'sd550};

    for (int s = 0; s < 4; s++) begin
      reset_seq();
      if (tbl[s].pre_abort) begin
        // 300 pixels of an untracked frame, then reset mid-frame
        sb_en = 1'b0;
        for (int i = 0; i < 300; i++) drive_pixel(0, i / 24, i % 24, 1'b0);
        reset_seq();
      end

      for (int i = 0; i < IN_DIM * IN_DIM; i++) begin
        if (tbl[s].enwin && (i == 176 || i == 401)) enable_gap();
        drive_pixel(tbl[s].pat, i / 24, i % 24, tbl[s].gaps);
      end

      // Last accept: final write now, done the cycle after
      chk("last_wr_en",   32'(bus.wr_en), 1);
      chk("last_wr_addr", 32'(bus.wr_addr), 143);
      chk("last_done_0",  32'(bus.done), 0);
      @(posedge clk); #1;
      chk("done_1",       32'(bus.done), 1);
      chk("done_wr_en_0", 32'(bus.wr_en), 0);
      chk("done_in_ready", 32'(bus.in_ready), 0);

      repeat (10) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 16'($urandom);
        @(posedge clk); #1;
        chk("post_done_wr_en",    32'(bus.wr_en), 0);
        chk("post_done_in_ready", 32'(bus.in_ready), 0);
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

      chk({tbl[s].name, "_wr_count"}, wr_cnt, 144);
      chk({tbl[s].name, "_sb_left"}, sbq.size(), 0);
      chk({tbl[s].name, "_addr0"}, mem[0], tbl[s].exp0);
      chk({tbl[s].name, "_addr143"}, mem[143], tbl[s].exp143);
      chk({tbl[s].name, "_done_sticky"}, 32'(bus.done), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
